hdmi_i2c_cfg: RTL and testbench

HDMI_I2C_CFG -- requirements
Module: hdmi_i2c_cfg

---
 rtl/hdmi_cfg_pkg.sv | 69 ++++++
 rtl/hdmi_i2c_byte.sv | 152 +++++++++++++++
 rtl/hdmi_i2c_cfg.sv | 208 ++++++++++++++++++++
 tb/tb_hdmi_i2c_cfg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter I2C configuration walker.
// The optional NACK retry feature is enabled by defining HDMI_I2C_CFG_RETRY_EN.
package hdmi_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_START = 4'd2,
        ST_ADDR  = 4'd3,
        ST_REG   = 4'd4,
        ST_DATA  = 4'd5,
        ST_STOP  = 4'd6,
        ST_NEXT  = 4'd7,
        ST_DONE  = 4'd8,
        ST_ERR   = 4'd9
    } cfg_state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_BYTE  = 2'd1,
        CMD_STOP  = 2'd2
    } i2c_cmd_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } tbl_entry_t;

    localparam logic [15:0] TBL_TERM    = 16'hFFFF;
    localparam logic [1:0]  RETRY_LIMIT = 2'd3;

    // Bus levels {scl, sda_oe} for one quarter of a START, data/ACK bit or STOP.
    function automatic logic [1:0] bus_drive(input i2c_cmd_e   cmd,
                                             input logic [7:0] data,
                                             input logic [3:0] bit_idx,
                                             input logic [1:0] qtr);
        logic       bit_val;
        logic [1:0] res;
        bit_val = 1'b1;
        res     = 2'b10;
        case (cmd)
            CMD_START: begin
                case (qtr)
                    2'd0:       res = 2'b10;
                    2'd1, 2'd2: res = 2'b11;
                    default:    res = 2'b01;
                endcase
            end
            CMD_BYTE: begin
                if (bit_idx < 4'd8) begin
                    bit_val = data[3'd7 - bit_idx[2:0]];
                end else begin
                    bit_val = 1'b1;
                end
                res = {(qtr == 2'd1) || (qtr == 2'd2), ~bit_val};
            end
            CMD_STOP: begin
                case (qtr)
                    2'd0:    res = 2'b01;
                    2'd1:    res = 2'b11;
                    default: res = 2'b10;
                endcase
            end
            default: res = 2'b10;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hdmi_i2c_byte.sv
// I2C bit engine: quarter-tick divider plus START / byte+ACK / STOP sequencing.
// One command may be queued ahead so consecutive bits keep an exact SCL period.
module hdmi_i2c_byte
    import hdmi_cfg_pkg::*;
#(
    parameter int unsigned DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  i2c_cmd_e   cmd_i,
    input  logic [7:0] byte_i,
    input  logic       sda_i,
    output logic       rdy_o,
    output logic       ack_ok_o,
    output logic       scl_o,
    output logic       sda_oe_o
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          run_q,    run_d;
    i2c_cmd_e      cmd_q,    cmd_d;
    logic [7:0]    byte_q,   byte_d;
    logic [3:0]    bit_q,    bit_d;
    logic [1:0]    qtr_q,    qtr_d;
    logic [DW-1:0] div_q,    div_d;
    logic          pend_q,   pend_d;
    i2c_cmd_e      pcmd_q,   pcmd_d;
    logic [7:0]    pbyte_q,  pbyte_d;
    logic          rdy_q,    rdy_d;
    logic          ack_ok_q, ack_ok_d;
    logic          scl_q,    scl_d;
    logic          oe_q,     oe_d;
    logic          tick_s;
    logic          load_s;
    logic [1:0]    drive_s;

    assign tick_s = run_q && (div_q == DIV_LAST);

    // Next-state: divider, quarter/bit stepping, command queue and bus levels.
    always_comb begin
        run_d    = run_q;
        cmd_d    = cmd_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        qtr_d    = qtr_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pcmd_d   = pcmd_q;
        pbyte_d  = pbyte_q;
        rdy_d    = 1'b0;
        ack_ok_d = ack_ok_q;
        load_s   = 1'b0;
        if (go_i) begin
            pend_d  = 1'b1;
            pcmd_d  = cmd_i;
            pbyte_d = byte_i;
        end else begin
            pend_d  = pend_q;
        end
        if (!run_q) begin
            div_d  = '0;
            load_s = pend_d;
        end else if (tick_s) begin
            div_d = '0;
            // Hand-off point: START is past its falling edge, or the ACK has been sampled.
            if ((qtr_q == 2'd2) &&
                ((cmd_q == CMD_START) || ((cmd_q == CMD_BYTE) && (bit_q == 4'd8)))) begin
                rdy_d    = 1'b1;
                ack_ok_d = (cmd_q == CMD_BYTE) ? ~sda_i : 1'b1;
            end else begin
                rdy_d    = 1'b0;
            end
            if (qtr_q == 2'd3) begin
                if ((cmd_q != CMD_BYTE) || (bit_q == 4'd8)) begin
                    rdy_d = rdy_d | (cmd_q == CMD_STOP);
                    if (pend_d) begin
                        load_s = 1'b1;
                    end else begin
                        run_d  = 1'b0;
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                    qtr_d = 2'd0;
                end
            end else begin
                qtr_d = qtr_q + 2'd1;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
        if (load_s) begin
            run_d  = 1'b1;
            cmd_d  = pcmd_d;
            byte_d = pbyte_d;
            bit_d  = 4'd0;
            qtr_d  = 2'd0;
            pend_d = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        drive_s = bus_drive(cmd_d, byte_d, bit_d, qtr_d);
        if (run_d) begin
            scl_d = drive_s[1];
            oe_d  = drive_s[0];
        end else begin
            scl_d = scl_q;
            oe_d  = oe_q;
        end
    end

    // State registers with synchronous reset to a released, idle bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            cmd_q    <= CMD_START;
            byte_q   <= 8'd0;
            bit_q    <= 4'd0;
            qtr_q    <= 2'd0;
            div_q    <= '0;
            pend_q   <= 1'b0;
            pcmd_q   <= CMD_START;
            pbyte_q  <= 8'd0;
            rdy_q    <= 1'b0;
            ack_ok_q <= 1'b0;
            scl_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            run_q    <= run_d;
            cmd_q    <= cmd_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            qtr_q    <= qtr_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pcmd_q   <= pcmd_d;
            pbyte_q  <= pbyte_d;
            rdy_q    <= rdy_d;
            ack_ok_q <= ack_ok_d;
            scl_q    <= scl_d;
            oe_q     <= oe_d;
        end
    end

    assign rdy_o    = rdy_q;
    assign ack_ok_o = ack_ok_q;
    assign scl_o    = scl_q;
    assign sda_oe_o = oe_q;

endmodule

// File: rtl/hdmi_i2c_cfg.sv
// Walks an external {reg,val} table and writes each entry to the HDMI transmitter over I2C.
// Define HDMI_I2C_CFG_RETRY_EN to retry a NACKed entry up to RETRY_LIMIT times before ERR.
module hdmi_i2c_cfg
    import hdmi_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned I2C_HZ   = 100_000,
    parameter logic [6:0]  DEV_ADDR = 7'h4C
) (
    input  logic        fpga_sysclk,
    input  logic        rst_sys,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        scl_o,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int unsigned DIV_RAW = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned DIV     = (DIV_RAW < 3) ? 3 : DIV_RAW;

    cfg_state_e state_q;
    logic [7:0] tbl_addr_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       go_q;
    i2c_cmd_e   cmd_q;
    logic [7:0] byte_q;
    tbl_entry_t entry_q;
    logic       nack_q;
    logic       fetch_wait_q;
`ifdef HDMI_I2C_CFG_RETRY_EN
    logic [1:0] retry_q;
`endif
    logic       rdy_s;
    logic       ack_ok_s;

    hdmi_i2c_byte #(
        .DIV (DIV)
    ) u_byte (
        .clk_i    (fpga_sysclk),
        .rst_i    (rst_sys),
        .go_i     (go_q),
        .cmd_i    (cmd_q),
        .byte_i   (byte_q),
        .sda_i    (sda_i),
        .rdy_o    (rdy_s),
        .ack_ok_o (ack_ok_s),
        .scl_o    (scl_o),
        .sda_oe_o (sda_oe)
    );

    // Table sequencer; commands to the bit engine are issued as one-cycle go pulses.
    always_ff @(posedge fpga_sysclk) begin
        if (rst_sys) begin
            state_q      <= ST_IDLE;
            tbl_addr_q   <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            go_q         <= 1'b0;
            cmd_q        <= CMD_START;
            byte_q       <= 8'd0;
            entry_q      <= '0;
            nack_q       <= 1'b0;
            fetch_wait_q <= 1'b0;
`ifdef HDMI_I2C_CFG_RETRY_EN
            retry_q      <= 2'd0;
`endif
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_FETCH;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        tbl_addr_q   <= 8'd0;
                        fetch_wait_q <= 1'b1;
                    end else begin
                        busy_q       <= 1'b0;
                    end
                end
                // The first FETCH cycle lets the table catch up with a new tbl_addr.
                ST_FETCH: begin
                    if (fetch_wait_q) begin
                        fetch_wait_q <= 1'b0;
                    end else if (tbl_data == TBL_TERM) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        entry_q <= tbl_data;
                        nack_q  <= 1'b0;
`ifdef HDMI_I2C_CFG_RETRY_EN
                        retry_q <= 2'd0;
`endif
                        go_q    <= 1'b1;
                        cmd_q   <= CMD_START;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (rdy_s) begin
                        go_q    <= 1'b1;
                        cmd_q   <= CMD_BYTE;
                        byte_q  <= {DEV_ADDR, 1'b0};
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rdy_s) begin
                        go_q <= 1'b1;
                        if (ack_ok_s) begin
                            cmd_q   <= CMD_BYTE;
                            byte_q  <= entry_q.reg_addr;
                            state_q <= ST_REG;
                        end else begin
                            cmd_q   <= CMD_STOP;
                            nack_q  <= 1'b1;
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_REG: begin
                    if (rdy_s) begin
                        go_q <= 1'b1;
                        if (ack_ok_s) begin
                            cmd_q   <= CMD_BYTE;
                            byte_q  <= entry_q.val;
                            state_q <= ST_DATA;
                        end else begin
                            cmd_q   <= CMD_STOP;
                            nack_q  <= 1'b1;
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_DATA: begin
                    if (rdy_s) begin
                        go_q    <= 1'b1;
                        cmd_q   <= CMD_STOP;
                        nack_q  <= ~ack_ok_s;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rdy_s) begin
`ifdef HDMI_I2C_CFG_RETRY_EN
                        if (nack_q && (retry_q != RETRY_LIMIT)) begin
                            retry_q <= retry_q + 2'd1;
                            nack_q  <= 1'b0;
                            go_q    <= 1'b1;
                            cmd_q   <= CMD_START;
                            state_q <= ST_START;
                        end else if (nack_q) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_NEXT;
                        end
`else
                        if (nack_q) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_NEXT;
                        end
`endif
                    end
                end
                // A full 256-entry sweep ends the pass even without a terminator.
                ST_NEXT: begin
                    tbl_addr_q <= tbl_addr_q + 8'd1;
                    if (tbl_addr_q == 8'hFF) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q      <= ST_FETCH;
                        fetch_wait_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_ERR: begin
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tbl_addr = tbl_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hdmi_i2c_cfg.sv
// Self-checking bench for hdmi_i2c_cfg with an I2C slave/bus monitor and a table-level model.
module tb_hdmi_i2c_cfg;

    localparam int BUDGET = 8000;
`ifdef HDMI_I2C_CFG_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data = 16'hFFFF;
    logic        busy, done, err, scl, sda_oe, sda_i;
    logic [15:0] table_mem [256];
    logic        slave_low = 1'b0;
    logic        nack_addr = 1'b0;

    int compared = 0;
    int mismatched = 0;

    hdmi_i2c_cfg #(
        .CLK_HZ (4_000_000),
        .I2C_HZ (100_000)
    ) dut (
        .fpga_sysclk (clk),
        .rst_sys     (rst),
        .start       (start),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .scl_o       (scl),
        .sda_oe      (sda_oe),
        .sda_i       (sda_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tbl_data <= table_mem[tbl_addr];

    assign sda_i = ~(sda_oe | slave_low);

    // Bus monitor and ACKing slave, sampled on the falling clock edge.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic [8:0]  sh = 9'd0;
    int          bitcnt = 0;
    int          byteidx = 0;
    int          starts = 0, stops = 0, dones = 0, scl_edges = 0;
    int          periods = 0, bad_period = 0;
    longint      cyc = 0;
    longint      last_rise = -1;
    logic [7:0]  cap_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) dones = dones + 1;
        if (scl && prev_scl && (sda_i !== prev_sda)) begin
            if (!sda_i) begin
                starts = starts + 1; bitcnt = 0; byteidx = 0; last_rise = -1;
            end else begin
                stops = stops + 1; bitcnt = 0;
            end
        end else if (scl && !prev_scl) begin
            scl_edges = scl_edges + 1;
            if (last_rise >= 0) begin
                periods = periods + 1;
                if (cyc - last_rise != 40) bad_period = bad_period + 1;
            end
            last_rise = cyc;
            sh = {sh[7:0], sda_i};
            bitcnt = bitcnt + 1;
            if (bitcnt == 9) cap_q.push_back(sh[8:1]);
        end else if (!scl && prev_scl) begin
            scl_edges = scl_edges + 1;
            if (bitcnt == 8) begin
                slave_low = !(nack_addr && byteidx == 0);
            end else if (bitcnt == 9) begin
                slave_low = 1'b0; bitcnt = 0; byteidx = byteidx + 1;
            end
        end
        prev_scl = scl;
        prev_sda = sda_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected bus bytes and pass outcome straight from the table contents.
    logic [7:0] exp_q [$];
    int exp_frames, exp_done, exp_err, exp_addr;

    task automatic build_expect();
        exp_q.delete();
        exp_frames = 0; exp_done = 0; exp_err = 0; exp_addr = 0;
        for (int i = 0; i < 256; i++) begin
            if (table_mem[i] == 16'hFFFF) begin
                exp_addr = i; exp_done = 1; break;
            end
            if (nack_addr) begin
                for (int a = 0; a < ATTEMPTS; a++) begin
                    exp_q.push_back(8'h98); exp_frames++;
                end
                exp_err = 1; exp_addr = i; break;
            end
            exp_q.push_back(8'h98);
            exp_q.push_back(table_mem[i][15:8]);
            exp_q.push_back(table_mem[i][7:0]);
            exp_frames++;
            if (i == 255) begin
                exp_addr = 0; exp_done = 1;
            end
        end
    endtask

    task automatic run_pass(input string tag, input int extra);
        int t, ex, b_cap, b_st, b_sp, b_dn, b_bp, b_pr;
        ex = extra;
        build_expect();
        b_cap = cap_q.size(); b_st = starts; b_sp = stops; b_dn = dones;
        b_bp = bad_period; b_pr = periods;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        t = 0;
        while (busy && t < BUDGET) begin
            @(negedge clk);
            t++;
            if (ex > 0 && (t % 311) == 0 && busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                ex--; t++;
            end
        end
        check({tag, "_timeout"}, 32'(t < BUDGET), 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_nbytes"}, 32'(cap_q.size() - b_cap), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b_cap + i < cap_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[b_cap + i]), 32'(exp_q[i]));
        end
        check({tag, "_starts"}, 32'(starts - b_st), 32'(exp_frames));
        check({tag, "_stops"}, 32'(stops - b_sp), 32'(exp_frames));
        check({tag, "_dones"}, 32'(dones - b_dn), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_addr"}, 32'(tbl_addr), 32'(exp_addr));
        check({tag, "_badper"}, 32'(bad_period - b_bp), 32'd0);
        if (exp_frames > 0) check({tag, "_periods"}, 32'(periods - b_pr > 0), 32'd1);
        check({tag, "_idle_scl"}, 32'(scl), 32'd1);
        check({tag, "_idle_oe"}, 32'(sda_oe), 32'd0);
    endtask

    initial begin
        int lat, b_edges, b_dn, t, n;
        for (int i = 0; i < 256; i++) table_mem[i] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(tbl_addr), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        table_mem[0] = 16'h0F01; table_mem[1] = 16'h6100; table_mem[2] = 16'hFFFF;
        run_pass("two", 0);

        table_mem[0] = 16'hFFFF;
        b_edges = scl_edges; b_dn = dones;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("empty_lat", 32'((lat >= 2) && (lat <= 3)), 32'd1);
        repeat (5) @(negedge clk);
        check("empty_scl", 32'(scl_edges - b_edges), 32'd0);
        check("empty_dones", 32'(dones - b_dn), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);

        nack_addr = 1'b1;
        table_mem[0] = 16'h0F01; table_mem[1] = 16'hFFFF;
        run_pass("nack", 0);
        repeat (20) @(negedge clk);
        check("nack_sticky", 32'(err), 32'd1);
        nack_addr = 1'b0;

        table_mem[0] = 16'h0F01; table_mem[1] = 16'h6100; table_mem[2] = 16'hFFFF;
        run_pass("busy_start", 3);

        table_mem[2] = 16'h1234; table_mem[3] = 16'hFFFF;
        n = cap_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (cap_q.size() < n + 5 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_reach", 32'(t < BUDGET), 32'd1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_scl", 32'(scl), 32'd1);
        check("rstmid_oe", 32'(sda_oe), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_addr", 32'(tbl_addr), 32'd0);
        rst = 1'b0;
        slave_low = 1'b0;
        repeat (5) @(negedge clk);
        run_pass("after_rst", 0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
                table_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
            table_mem[n] = 16'hFFFF;
            run_pass($sformatf("rnd%0d", r), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
